// File: rtl/cve2_obi_sram_adapter.sv
// OBI slave adapter driving a single-port synchronous SRAM with fixed-latency, in-order responses.
// Optional range checking with error responses: define CVE2_SRAM_ADAPTER_RANGE_ERR_EN.
module cve2_obi_sram_adapter #(
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned MemDepth       = 16384,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [3:0]                  be_i,
  input  logic [31:0]                 addr_i,
  input  logic [31:0]                 wdata_i,
  output logic                        rvalid_o,
  output logic [31:0]                 rdata_o,
  output logic                        err_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [$clog2(MemDepth)-1:0] mem_addr_o,
  output logic [31:0]                 mem_wmask_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic [31:0]                 mem_rdata_i,
  output logic                        busy_o
);

  localparam int unsigned AW = $clog2(MemDepth);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxOut = CW'(MaxOutstanding);

  logic [CW-1:0]          out_cnt_q, out_cnt_d;
  logic [ReadLatency-1:0] valid_q, err_q;
  logic                   rd0_q;
  logic                   in_range, req_err, retiring;

`ifdef CVE2_SRAM_ADAPTER_RANGE_ERR_EN
  // 33-bit bounds so a window ending at 2^32 does not wrap to zero
  localparam logic [32:0] RangeLo = {1'b0, BaseAddr};
  localparam logic [32:0] RangeHi = RangeLo + (33'(MemDepth) << 2);

  assign in_range = ({1'b0, addr_i} >= RangeLo) && ({1'b0, addr_i} < RangeHi);
  assign req_err  = ~in_range;
`else
  assign in_range = 1'b1;
  assign req_err  = 1'b0;
`endif

  assign retiring = valid_q[ReadLatency-1];
  assign rvalid_o = retiring;
  assign err_o    = retiring & err_q[ReadLatency-1];
  assign busy_o   = (out_cnt_q != '0);
  assign gnt_o    = req_i & ((out_cnt_q < MaxOut) | retiring);

  assign mem_req_o   = gnt_o & in_range;
  assign mem_we_o    = we_i;
  assign mem_addr_o  = AW'((addr_i - BaseAddr) >> 2);
  assign mem_wdata_o = wdata_i;
  assign mem_wmask_o = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (gnt_o && !retiring) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end else if (!gnt_o && retiring) begin
      out_cnt_d = out_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      rd0_q     <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      valid_q[0] <= gnt_o;
      err_q[0]   <= gnt_o & req_err;
      rd0_q      <= gnt_o & ~we_i;
      for (int i = 1; i < int'(ReadLatency); i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  // Read data is gated to zero when captured, so later stages only need to shift it
  if (ReadLatency == 1) begin : g_comb_rdata
    assign rdata_o = (retiring && rd0_q && !err_q[0]) ? mem_rdata_i : '0;
  end else begin : g_reg_rdata
    logic [31:0] data_q [1:ReadLatency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 1; i < int'(ReadLatency); i++) begin
          data_q[i] <= '0;
        end
      end else begin
        data_q[1] <= (valid_q[0] && rd0_q && !err_q[0]) ? mem_rdata_i : '0;
        for (int i = 2; i < int'(ReadLatency); i++) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign rdata_o = data_q[ReadLatency-1];
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(gnt_o && !retiring && out_cnt_q == MaxOut));
      assert (!(retiring && !gnt_o && out_cnt_q == '0));
    end
  end

endmodule

// File: tb/tb_cve2_obi_sram_adapter.sv
// Directed bench for cve2_obi_sram_adapter: three instances (basic, deep pipeline, offset base).
module tb_cve2_obi_sram_adapter;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_mreq;
    logic [9:0]  exp_idx;
    logic [31:0] exp_mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_b_n;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        req_a, req_b, req_c;

  logic        gnt_a, rvalid_a, err_a, mreq_a, mwe_a, busy_a;
  logic [31:0] rdata_a, mmask_a, mwdata_a, mrdata_a;
  logic [9:0]  maddr_a;
  logic        gnt_b, rvalid_b, err_b, mreq_b, mwe_b, busy_b;
  logic [31:0] rdata_b, mmask_b, mwdata_b, mrdata_b;
  logic [9:0]  maddr_b;
  logic        gnt_c, rvalid_c, err_c, mreq_c, mwe_c, busy_c;
  logic [31:0] rdata_c, mmask_c, mwdata_c, mrdata_c;
  logic [9:0]  maddr_c;

  cve2_obi_sram_adapter #(.BaseAddr(32'h0), .MemDepth(1024), .ReadLatency(1), .MaxOutstanding(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .gnt_o(gnt_a), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
    .mem_req_o(mreq_a), .mem_we_o(mwe_a), .mem_addr_o(maddr_a), .mem_wmask_o(mmask_a),
    .mem_wdata_o(mwdata_a), .mem_rdata_i(mrdata_a), .busy_o(busy_a));

  cve2_obi_sram_adapter #(.BaseAddr(32'h0), .MemDepth(1024), .ReadLatency(3), .MaxOutstanding(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n & rst_b_n), .req_i(req_b), .gnt_o(gnt_b), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .mem_req_o(mreq_b), .mem_we_o(mwe_b), .mem_addr_o(maddr_b), .mem_wmask_o(mmask_b),
    .mem_wdata_o(mwdata_b), .mem_rdata_i(mrdata_b), .busy_o(busy_b));

  cve2_obi_sram_adapter #(.BaseAddr(32'h8000_0000), .MemDepth(1024), .ReadLatency(1), .MaxOutstanding(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .gnt_o(gnt_c), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .err_o(err_c),
    .mem_req_o(mreq_c), .mem_we_o(mwe_c), .mem_addr_o(maddr_c), .mem_wmask_o(mmask_c),
    .mem_wdata_o(mwdata_c), .mem_rdata_i(mrdata_c), .busy_o(busy_c));

  // SRAM models: masked write, registered read; contents seeded while rst_n is low
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] mem_c [1024];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h1000_0000 + 32'(i);
        mem_c[i] <= 32'h0;
      end
      mrdata_a <= 32'h0;
      mrdata_b <= 32'h0;
      mrdata_c <= 32'h0;
    end else begin
      if (mreq_a) begin
        if (mwe_a) mem_a[maddr_a] <= (mem_a[maddr_a] & ~mmask_a) | (mwdata_a & mmask_a);
        else       mrdata_a <= mem_a[maddr_a];
      end
      if (mreq_b) begin
        if (mwe_b) mem_b[maddr_b] <= (mem_b[maddr_b] & ~mmask_b) | (mwdata_b & mmask_b);
        else       mrdata_b <= mem_b[maddr_b];
      end
      if (mreq_c) begin
        if (mwe_c) mem_c[maddr_c] <= (mem_c[maddr_c] & ~mmask_c) | (mwdata_c & mmask_c);
        else       mrdata_c <= mem_c[maddr_c];
      end
    end
  end

  // Selected single-latency instance for the table runner (0 = u_a, 1 = u_c)
  int          sel;
  logic        gnt_s, rvalid_s, err_s, mreq_s, mwe_s, busy_s;
  logic [31:0] rdata_s, mmask_s, mwdata_s;
  logic [9:0]  maddr_s;

  always_comb begin
    gnt_s = gnt_a; rvalid_s = rvalid_a; err_s = err_a; mreq_s = mreq_a; mwe_s = mwe_a;
    busy_s = busy_a; rdata_s = rdata_a; mmask_s = mmask_a; mwdata_s = mwdata_a; maddr_s = maddr_a;
    if (sel == 1) begin
      gnt_s = gnt_c; rvalid_s = rvalid_c; err_s = err_c; mreq_s = mreq_c; mwe_s = mwe_c;
      busy_s = busy_c; rdata_s = rdata_c; mmask_s = mmask_c; mwdata_s = mwdata_c; maddr_s = maddr_c;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                              input logic mr, input logic [9:0] ix, input logic [31:0] m,
                              input logic [31:0] rd, input logic e);
    vec_t v;
    v.we = w; v.be = b; v.addr = a; v.wdata = d; v.exp_mreq = mr; v.exp_idx = ix;
    v.exp_mask = m; v.exp_rdata = rd; v.exp_err = e;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
    if (sel == 0) req_a = 1'b1; else req_c = 1'b1;
    #1;
    chk({tag, " gnt"}, 32'(gnt_s), 32'd1);
    chk({tag, " mem_req"}, 32'(mreq_s), 32'(v.exp_mreq));
    chk({tag, " rvalid_early"}, 32'(rvalid_s), 32'd0);
    if (v.exp_mreq) begin
      chk({tag, " mem_addr"}, 32'(maddr_s), 32'(v.exp_idx));
      chk({tag, " mem_we"}, 32'(mwe_s), 32'(v.we));
      if (v.we) begin
        chk({tag, " mem_wmask"}, mmask_s, v.exp_mask);
        chk({tag, " mem_wdata"}, mwdata_s, v.wdata);
      end
    end
    @(negedge clk);
    req_a = 1'b0; req_c = 1'b0;
    #1;
    chk({tag, " rvalid"}, 32'(rvalid_s), 32'd1);
    chk({tag, " rdata"}, rdata_s, v.exp_rdata);
    chk({tag, " err"}, 32'(err_s), 32'(v.exp_err));
    chk({tag, " busy_resp"}, 32'(busy_s), 32'd1);
    @(negedge clk);
    #1;
    chk({tag, " rvalid_after"}, 32'(rvalid_s), 32'd0);
    chk({tag, " rdata_idle"}, rdata_s, 32'd0);
    chk({tag, " busy_idle"}, 32'(busy_s), 32'd0);
  endtask

  vec_t ta[$];
  vec_t tc[$];
  logic [8:0]  exp_gnt, exp_rv, exp_busy;
  logic [31:0] exp_rd [9];
  int          n_granted;
  logic        saw_rvalid;

  initial begin
    rst_n = 1'b0; rst_b_n = 1'b1; sel = 0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

    ta.push_back(mk(1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1, 10'd4,    32'hFFFF_FFFF, 32'h0,         0));
    ta.push_back(mk(0, 4'hF, 32'h0000_0010, 32'h0,         1, 10'd4,    32'h0,         32'hDEAD_BEEF, 0));
    ta.push_back(mk(1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1, 10'd8,    32'hFFFF_FFFF, 32'h0,         0));
    ta.push_back(mk(1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 1, 10'd8,    32'h00FF_00FF, 32'h0,         0));
    ta.push_back(mk(0, 4'hF, 32'h0000_0020, 32'h0,         1, 10'd8,    32'h0,         32'h11BB_33DD, 0));
    ta.push_back(mk(0, 4'hF, 32'h0000_0013, 32'h0,         1, 10'd4,    32'h0,         32'hDEAD_BEEF, 0));
    ta.push_back(mk(1, 4'h8, 32'h0000_0024, 32'h5566_7788, 1, 10'd9,    32'hFF00_0000, 32'h0,         0));
    ta.push_back(mk(0, 4'hF, 32'h0000_0024, 32'h0,         1, 10'd9,    32'h0,         32'h5500_0000, 0));
    ta.push_back(mk(1, 4'h0, 32'h0000_0010, 32'h0,         1, 10'd4,    32'h0000_0000, 32'h0,         0));
    ta.push_back(mk(0, 4'hF, 32'h0000_0010, 32'h0,         1, 10'd4,    32'h0,         32'hDEAD_BEEF, 0));
    ta.push_back(mk(1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 1, 10'd1023, 32'hFFFF_FFFF, 32'h0,         0));
    ta.push_back(mk(0, 4'hF, 32'h0000_0FFE, 32'h0,         1, 10'd1023, 32'h0,         32'hCAFE_F00D, 0));

    tc.push_back(mk(1, 4'hF, 32'h8000_0FFC, 32'h1234_5678, 1, 10'd1023, 32'hFFFF_FFFF, 32'h0,         0));
    tc.push_back(mk(0, 4'hF, 32'h8000_0FFC, 32'h0,         1, 10'd1023, 32'h0,         32'h1234_5678, 0));
`ifdef CVE2_SRAM_ADAPTER_RANGE_ERR_EN
    tc.push_back(mk(0, 4'hF, 32'h8000_1000, 32'h0,         0, 10'd0,    32'h0,         32'h0,         1));
    tc.push_back(mk(1, 4'hF, 32'h8000_1000, 32'hA5A5_A5A5, 0, 10'd0,    32'h0,         32'h0,         1));
    tc.push_back(mk(0, 4'hF, 32'h8000_0000, 32'h0,         1, 10'd0,    32'h0,         32'h0,         0));
    tc.push_back(mk(0, 4'hF, 32'h7FFF_FFFC, 32'h0,         0, 10'd0,    32'h0,         32'h0,         1));
    tc.push_back(mk(0, 4'hF, 32'hFFFF_FFFC, 32'h0,         0, 10'd0,    32'h0,         32'h0,         1));
`else
    tc.push_back(mk(1, 4'hF, 32'h8000_1000, 32'hA5A5_A5A5, 1, 10'd0,    32'hFFFF_FFFF, 32'h0,         0));
    tc.push_back(mk(0, 4'hF, 32'h8000_0000, 32'h0,         1, 10'd0,    32'h0,         32'hA5A5_A5A5, 0));
    tc.push_back(mk(0, 4'hF, 32'h7FFF_FFFC, 32'h0,         1, 10'd1023, 32'h0,         32'h1234_5678, 0));
`endif
    tc.push_back(mk(1, 4'hF, 32'h8000_0004, 32'h0BAD_CAFE, 1, 10'd1,    32'hFFFF_FFFF, 32'h0,         0));
    tc.push_back(mk(0, 4'hF, 32'h8000_0004, 32'h0,         1, 10'd1,    32'h0,         32'h0BAD_CAFE, 0));

    exp_gnt  = 9'b000011011;
    exp_rv   = 9'b011011000;
    exp_busy = 9'b011111110;
    exp_rd   = '{32'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h1000_0001,
                 32'h0, 32'h1000_0002, 32'h1000_0003, 32'h0};

    // Reset state
    #2;
    chk("rst gnt_a", 32'(gnt_a), 32'd0);
    chk("rst rvalid_a", 32'(rvalid_a), 32'd0);
    chk("rst rdata_a", rdata_a, 32'd0);
    chk("rst err_a", 32'(err_a), 32'd0);
    chk("rst busy_a", 32'(busy_a), 32'd0);
    chk("rst mem_req_a", 32'(mreq_a), 32'd0);
    chk("rst rvalid_b", 32'(rvalid_b), 32'd0);
    chk("rst rdata_b", rdata_b, 32'd0);
    chk("rst busy_b", 32'(busy_b), 32'd0);
    chk("rst err_c", 32'(err_c), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    sel = 0;
    foreach (ta[i]) run_vec($sformatf("a%0d", i), ta[i]);
    sel = 1;
    foreach (tc[i]) run_vec($sformatf("c%0d", i), tc[i]);

    // Outstanding limit on the 3-cycle instance, request held for 6 cycles
    n_granted = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_b = (c < 6); we = 1'b0; be = 4'hF; addr = 32'(n_granted * 4);
      #1;
      chk($sformatf("lim c%0d gnt", c), 32'(gnt_b), 32'(exp_gnt[c]));
      chk($sformatf("lim c%0d rvalid", c), 32'(rvalid_b), 32'(exp_rv[c]));
      chk($sformatf("lim c%0d rdata", c), rdata_b, exp_rd[c]);
      chk($sformatf("lim c%0d busy", c), 32'(busy_b), 32'(exp_busy[c]));
      if (gnt_b) n_granted++;
    end

    // Reset with two reads in flight
    @(negedge clk); req_b = 1'b1; addr = 32'h0;
    @(negedge clk); addr = 32'h4;
    #1;
    chk("mid pre busy", 32'(busy_b), 32'd1);
    @(negedge clk); req_b = 1'b0; rst_b_n = 1'b0;
    #1;
    chk("mid rst rvalid", 32'(rvalid_b), 32'd0);
    chk("mid rst busy", 32'(busy_b), 32'd0);
    @(negedge clk); rst_b_n = 1'b1;
    saw_rvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (rvalid_b) saw_rvalid = 1'b1;
    end
    chk("mid no rvalid", 32'(saw_rvalid), 32'd0);
    chk("mid busy idle", 32'(busy_b), 32'd0);
    @(negedge clk); req_b = 1'b1; addr = 32'h8;
    #1;
    chk("mid regrant", 32'(gnt_b), 32'd1);
    @(negedge clk); req_b = 1'b0;
    #1;
    chk("mid g+1 rvalid", 32'(rvalid_b), 32'd0);
    @(negedge clk);
    #1;
    chk("mid g+2 rvalid", 32'(rvalid_b), 32'd0);
    @(negedge clk);
    #1;
    chk("mid g+3 rvalid", 32'(rvalid_b), 32'd1);
    chk("mid g+3 rdata", rdata_b, 32'h1000_0002);
    @(negedge clk);
    #1;
    chk("mid g+4 busy", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
